// File: rtl/eth_tx_line.sv
// 10BASE-T transmit line stage: passes link pulses through in idle and sends
// Manchester-encoded frames with preamble/SFD and a trailing TP_IDL.
module eth_tx_line #(
    parameter int HALF_BIT     = 4,
    parameter int TPIDL_CYCLES = 20
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       tx_nlp,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       td_p,
    output logic       td_n,
    output logic       tx_busy,
    output logic       underrun,
    output logic       nlp_skip
);

    localparam int HCW = (HALF_BIT > 1) ? $clog2(HALF_BIT) : 1;
    localparam int TCW = $clog2(TPIDL_CYCLES + 1);
    localparam logic [HCW-1:0] HALF_LAST  = HCW'(HALF_BIT - 1);
    localparam logic [TCW-1:0] TPIDL_LAST = TCW'(TPIDL_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PRE, DATA, TPIDL} state_t;

    state_t         state;
    logic [7:0]     hold_data;
    logic           hold_last;
    logic           hold_valid;
    logic [7:0]     shift_data;
    logic           shift_last;
    logic [HCW-1:0] half_cnt;
    logic           phase;
    logic [2:0]     bit_idx;
    logic [2:0]     pre_idx;
    logic [TCW-1:0] tpidl_cnt;
    logic           nlp_arm;
    logic           nlp_prev;

    logic       accept;
    logic       nlp_rise;
    logic       arm_now;
    logic       half_end;
    logic       bit_end;
    logic       byte_end;
    logic [7:0] cur_byte;
    logic       cur_bit;
    logic       line_level;
    logic       next_avail;
    logic [7:0] next_data;
    logic       next_last;

    assign accept   = tx_valid && tx_ready;
    assign nlp_rise = tx_nlp && !nlp_prev;
    assign arm_now  = nlp_arm || (nlp_rise && state == IDLE);
    assign half_end = (half_cnt == HALF_LAST);
    assign bit_end  = half_end && phase;
    assign byte_end = bit_end && (bit_idx == 3'd7);

    // Preamble bytes are generated here so the holding register stays untouched.
    assign cur_byte   = (state == PRE) ? ((pre_idx == 3'd7) ? 8'hD5 : 8'h55) : shift_data;
    assign cur_bit    = cur_byte[bit_idx];
    assign line_level = phase ? cur_bit : !cur_bit;

    // A byte accepted on the very edge a byte finishes still counts as available.
    assign next_avail = hold_valid || accept;
    assign next_data  = hold_valid ? hold_data : tx_data;
    assign next_last  = hold_valid ? hold_last : tx_last;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            hold_data  <= '0;
            hold_last  <= 1'b0;
            hold_valid <= 1'b0;
            shift_data <= '0;
            shift_last <= 1'b0;
            half_cnt   <= '0;
            phase      <= 1'b0;
            bit_idx    <= '0;
            pre_idx    <= '0;
            tpidl_cnt  <= '0;
            nlp_arm    <= 1'b0;
            nlp_prev   <= 1'b0;
            tx_ready   <= 1'b0;
            td_p       <= 1'b0;
            td_n       <= 1'b0;
            tx_busy    <= 1'b0;
            underrun   <= 1'b0;
            nlp_skip   <= 1'b0;
        end else begin
            underrun <= 1'b0;
            nlp_skip <= nlp_rise && (state != IDLE);
            nlp_prev <= tx_nlp;
            tx_busy  <= (state != IDLE);

            if (!tx_nlp)
                nlp_arm <= 1'b0;
            else if (nlp_rise && state == IDLE)
                nlp_arm <= 1'b1;

            if (accept) begin
                hold_valid <= 1'b1;
                hold_data  <= tx_data;
                hold_last  <= tx_last;
            end
            tx_ready <= !next_avail;

            case (state)
                IDLE: begin
                    td_p <= arm_now && tx_nlp;
                    td_n <= 1'b0;
                    if (hold_valid && !(tx_nlp && arm_now))
                        state <= PRE;
                end
                PRE, DATA: begin
                    td_p     <= line_level;
                    td_n     <= !line_level;
                    half_cnt <= half_end ? '0 : half_cnt + HCW'(1);
                    if (half_end)
                        phase <= !phase;
                    if (bit_end)
                        bit_idx <= bit_idx + 3'd1;
                    if (state == PRE && byte_end) begin
                        pre_idx <= pre_idx + 3'd1;
                        if (pre_idx == 3'd7) begin
                            state      <= DATA;
                            shift_data <= hold_data;
                            shift_last <= hold_last;
                            hold_valid <= 1'b0;
                            tx_ready   <= 1'b1;
                        end
                    end
                    if (state == DATA && byte_end) begin
                        if (shift_last) begin
                            state <= TPIDL;
                        end else if (next_avail) begin
                            shift_data <= next_data;
                            shift_last <= next_last;
                            hold_valid <= 1'b0;
                            tx_ready   <= 1'b1;
                        end else begin
                            underrun <= 1'b1;
                            state    <= TPIDL;
                        end
                    end
                end
                TPIDL: begin
                    td_p <= 1'b1;
                    td_n <= 1'b0;
                    if (tpidl_cnt == TPIDL_LAST) begin
                        tpidl_cnt <= '0;
                        state     <= IDLE;
                    end else begin
                        tpidl_cnt <= tpidl_cnt + TCW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_tx_line.sv
// Randomised scoreboard bench for eth_tx_line: frames are modelled as expected
// line samples per busy cycle, plus directed link-pulse and reset scenarios.
module tb_eth_tx_line;

    localparam int HALF  = 4;
    localparam int TPIDL = 20;

    logic       clk;
    logic       resetn;
    logic       tx_nlp;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_ready;
    logic       td_p;
    logic       td_n;
    logic       tx_busy;
    logic       underrun;
    logic       nlp_skip;

    int vectors     = 0;
    int miscompares = 0;

    logic [1:0] exp_line[$];
    int         exp_und[$];
    logic [7:0] frame_bytes[$];

    int busy_len      = 0;
    int last_busy_len = 0;
    int underrun_seen = 0;
    int skip_count    = 0;
    int idle_high     = 0;
    int ready_falls   = 0;
    logic prev_busy   = 1'b0;
    logic prev_und    = 1'b0;
    logic prev_skip   = 1'b0;
    logic prev_ready  = 1'b0;

    eth_tx_line #(.HALF_BIT(HALF), .TPIDL_CYCLES(TPIDL)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .tx_nlp   (tx_nlp),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_last  (tx_last),
        .tx_ready (tx_ready),
        .td_p     (td_p),
        .td_n     (td_n),
        .tx_busy  (tx_busy),
        .underrun (underrun),
        .nlp_skip (nlp_skip)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endfunction

    // Expected line: each bit is HALF cycles of its complement then HALF cycles of itself.
    function automatic void pushFrame(input int expect_underrun);
        logic [7:0] b;
        for (int k = 0; k < 8 + frame_bytes.size(); k++) begin
            b = (k < 7) ? 8'h55 : (k == 7) ? 8'hD5 : frame_bytes[k-8];
            for (int i = 0; i < 8; i++) begin
                for (int h = 0; h < HALF; h++) exp_line.push_back({~b[i], b[i]});
                for (int h = 0; h < HALF; h++) exp_line.push_back({b[i], ~b[i]});
            end
        end
        for (int t = 0; t < TPIDL; t++) exp_line.push_back(2'b10);
        exp_und.push_back(expect_underrun);
    endfunction

    always @(negedge clk) begin
        if (!resetn) begin
            prev_busy  = 1'b0;
            prev_und   = 1'b0;
            prev_skip  = 1'b0;
            prev_ready = 1'b0;
            busy_len   = 0;
            underrun_seen = 0;
        end else begin
            if (tx_busy) begin
                busy_len++;
                if (exp_line.size() == 0) checkOutput("line_extra_sample", 1, 0);
                else checkOutput("line_level", {td_p, td_n}, exp_line.pop_front());
            end else if (td_p) begin
                idle_high++;
            end
            if (underrun) begin
                underrun_seen++;
                if (prev_und) checkOutput("underrun_width", 2, 1);
            end
            if (nlp_skip) begin
                skip_count++;
                if (prev_skip) checkOutput("nlp_skip_width", 2, 1);
            end
            if (prev_ready && !tx_ready) ready_falls++;
            if (prev_busy && !tx_busy) begin
                checkOutput("line_samples_left", exp_line.size(), 0);
                checkOutput("lines_after_tpidl", {td_p, td_n}, 0);
                if (exp_und.size() == 0) checkOutput("unexpected_frame", 1, 0);
                else checkOutput("underrun_count", underrun_seen, exp_und.pop_front());
                last_busy_len = busy_len;
                busy_len      = 0;
                underrun_seen = 0;
            end
            prev_busy  = tx_busy;
            prev_und   = underrun;
            prev_skip  = nlp_skip;
            prev_ready = tx_ready;
        end
    end

    // Offer one byte after 'idle' cycles and hold it until accepted; tx_valid stays high afterwards.
    task automatic applyStimulus(input logic [7:0] d, input logic l, input int idle);
        int n;
        if (idle > 0) begin
            tx_valid = 1'b0;
            repeat (idle) @(negedge clk);
        end
        tx_valid = 1'b1;
        tx_data  = d;
        tx_last  = l;
        n = 0;
        while (!tx_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("byte_accepted", tx_ready, 1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic driveFrame(input bit with_last, input int first_gap, input int max_gap);
        pushFrame(with_last ? 0 : 1);
        for (int k = 0; k < frame_bytes.size(); k++)
            applyStimulus(frame_bytes[k], with_last && (k == frame_bytes.size() - 1),
                          (k == 0) ? first_gap : $urandom_range(0, max_gap));
        tx_valid = 1'b0;
        tx_last  = 1'b0;
    endtask

    task automatic waitFrameDone();
        int n;
        n = 0;
        while (!tx_busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("busy_start", tx_busy, 1);
        n = 0;
        while (tx_busy && n < 6000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("busy_end", tx_busy, 0);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic nlpPulse(input int delay, input int width);
        repeat (delay) @(negedge clk);
        tx_nlp = 1'b1;
        repeat (width) @(negedge clk);
        tx_nlp = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base;
        int n;
        resetn   = 1'b0;
        tx_nlp   = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        tx_last  = 1'b0;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("reset_outputs", {td_p, td_n, tx_ready, tx_busy, underrun, nlp_skip}, 0);
        end
        resetn = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_reset", tx_ready, 1);
        checkOutput("busy_after_reset", tx_busy, 0);
        repeat (3) @(negedge clk);

        base = skip_count;
        tx_nlp = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            checkOutput("nlp_td_p", td_p, (i <= 8) ? 1 : 0);
            checkOutput("nlp_td_n", td_n, 0);
            if (i == 8) tx_nlp = 1'b0;
        end
        checkOutput("nlp_no_skip", skip_count - base, 0);

        frame_bytes = '{8'hA5};
        driveFrame(1'b1, 0, 0);
        waitFrameDone();
        checkOutput("single_busy_len", last_busy_len, 128 * HALF + 16 * HALF + TPIDL);

        ready_falls = 0;
        frame_bytes = '{8'h01, 8'hFF, 8'h00};
        driveFrame(1'b1, 0, 0);
        waitFrameDone();
        checkOutput("b2b_ready_toggles", ready_falls, 3);

        frame_bytes = '{8'h12};
        driveFrame(1'b0, 0, 0);
        waitFrameDone();

        // Second byte arrives on the edge that completes the first byte's last half-bit.
        frame_bytes = '{8'h3C, 8'hC3};
        pushFrame(0);
        applyStimulus(8'h3C, 1'b0, 0);
        tx_valid = 1'b0;
        n = 0;
        while (!tx_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("jit_ready", tx_ready, 1);
        applyStimulus(8'hC3, 1'b1, 16 * HALF - 1);
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        waitFrameDone();

        base = skip_count;
        n = idle_high;
        frame_bytes = '{8'h96, 8'h69};
        fork
            driveFrame(1'b1, 0, 0);
            nlpPulse(200, 8);
        join
        waitFrameDone();
        checkOutput("midframe_skip", skip_count - base, 1);
        checkOutput("midframe_no_pulse", idle_high - n, 0);

        base = skip_count;
        n = idle_high;
        frame_bytes = '{8'h5A};
        fork
            nlpPulse(0, 8);
            driveFrame(1'b1, 3, 0);
        join
        waitFrameDone();
        checkOutput("idle_pulse_width", idle_high - n, 8);
        checkOutput("idle_pulse_no_skip", skip_count - base, 0);

        for (int f = 0; f < 8; f++) begin
            int len;
            bit with_last;
            len = $urandom_range(1, 5);
            with_last = ($urandom_range(0, 3) != 0);
            frame_bytes.delete();
            for (int k = 0; k < len; k++) frame_bytes.push_back(8'($urandom_range(0, 255)));
            driveFrame(with_last, $urandom_range(0, 10), 30);
            waitFrameDone();
        end

        frame_bytes = '{8'h77};
        driveFrame(1'b1, 0, 0);
        repeat (100) @(negedge clk);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        exp_line.delete();
        exp_und.delete();
        @(negedge clk);
        checkOutput("midreset_lines", {td_p, td_n}, 0);
        checkOutput("midreset_busy", tx_busy, 0);
        checkOutput("midreset_ready", tx_ready, 0);
        resetn = 1'b1;
        @(negedge clk);
        checkOutput("midreset_ready_release", tx_ready, 1);
        repeat (10) @(negedge clk);
        checkOutput("midreset_byte_discarded", tx_busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/eth_tx_line.md
# eth_tx_line

10BASE-T transmit line stage that consumes the link-pulse strobe `tx_nlp` from `eth_nlp` and a byte stream from the MAC. It emits either normal link pulses or Manchester-encoded frames on the differential pair `td_p`/`td_n`. It inserts preamble and SFD, ends every frame with TP_IDL, suppresses link pulses during frames, and reports underruns. It sits between `eth_nlp`/MAC TX and the TX pad drivers.

## Interface
- `HALF_BIT`, default 4: clk cycles per Manchester half-bit (80 MHz clk gives 10 Mbit/s).
- `TPIDL_CYCLES`, default 20: cycles of positive TP_IDL after the last bit (250 ns at 80 MHz).
- `clk`  in  1: single clock, rising edge.
- `resetn`  in  1: reset is synchronous and active-low.
- `tx_nlp`  in  1: link-pulse request from `eth_nlp`, level, high for the pulse duration.
- `tx_valid`  in  1: MAC byte valid.
- `tx_data`  in  8: MAC byte, sent LSB first; excludes preamble/SFD.
- `tx_last`  in  1: qualifies the final byte of the frame.
- `tx_ready`  out  1: byte accepted on a cycle where `tx_valid && tx_ready`.
- `td_p`  out  1: positive line driver.
- `td_n`  out  1: negative line driver.
- `tx_busy`  out  1: high in PRE, DATA and TPIDL.
- `underrun`  out  1: one-cycle pulse when a frame is aborted for missing data.
- `nlp_skip`  out  1: one-cycle pulse when a `tx_nlp` rising edge is suppressed.

## Operation
- Holding register (1 byte + last flag + valid) feeds a shift register. `tx_ready` is registered and equals `!hold_valid`. It is forced 0 while `resetn` is low.
- States: IDLE, PRE, DATA, TPIDL.
- **IDLE**
  - `td_p = nlp_arm && tx_nlp`, `td_n = 0`. `nlp_arm` is set by a `tx_nlp` rising edge sampled in IDLE and cleared when `tx_nlp` falls.
  - When `hold_valid` is set and no link pulse is in progress (`tx_nlp` low or `nlp_arm` clear), go to PRE. If a link pulse is in progress, wait until `tx_nlp` falls, then go to PRE.
- **PRE**
  - Sends 7 × 0x55 then 0xD5, LSB first, internally generated. The holding register is untouched.
  - After the last SFD bit, the held byte moves to the shift register, `hold_valid` clears, and the state goes to DATA.
- **DATA**
  - At the end of each byte:
    - If the current byte had `last`, go to TPIDL.
    - Else if `hold_valid`, load the next byte.
    - Else pulse `underrun` and go to TPIDL; the frame is truncated.
- **Manchester encoding**
  - Bit 1: first half low, second half high. Bit 0: first half high, second half low.
  - Encoded level L drives `td_p = L`, `td_n = ~L`.
- **TPIDL**
  - `td_p = 1`, `td_n = 0` for `TPIDL_CYCLES` cycles, then go to IDLE with both lines 0.
- **NLP suppression**
  - A `tx_nlp` rising edge outside IDLE pulses `nlp_skip` and produces no line activity.
  - A pulse already high when TPIDL exits is not emitted, because it was not armed.
- **Counters**
  - Half-bit counter: `$clog2(HALF_BIT)` bits.
  - Bit index: 3 bits. Preamble byte index: 3 bits.
  - TPIDL counter: `$clog2(TPIDL_CYCLES+1)` bits.
  - No counter wraps outside its terminal count.
- **Reset**
  - State IDLE, `hold_valid = 0`, `nlp_arm = 0`.
  - All outputs 0: `td_p`, `td_n`, `tx_ready`, `tx_busy`, `underrun`, `nlp_skip`.
  - A reset mid-frame returns both lines to 0 on the next edge with no TPIDL, and discards the held byte.

## Timing
- All outputs are registered.
- `td_p`/`td_n` reflect the state and half-bit one clock after the internal transition.
- The first preamble half-bit appears on `td_p` 2 cycles after the acceptance edge in IDLE with no link pulse in progress.
- Each bit takes `2*HALF_BIT` cycles. Each byte takes `16*HALF_BIT` cycles: 64 at the default.
- Preamble + SFD take `128*HALF_BIT` cycles: 512 at the default.
- `tx_ready` deasserts on the cycle after acceptance and reasserts on the cycle after the held byte moves to the shift register.
- A byte offered on the cycle its predecessor's last half-bit completes counts as available; no underrun occurs.
- `underrun` and `nlp_skip` are exactly 1 cycle wide.
- Link-pulse passthrough latency is 1 cycle from `tx_nlp` to `td_p`, and the pulse width is preserved.

## Test plan
- **Reset:** release after 5 cycles. Required: all outputs 0 during reset. `tx_ready = 1` on the first cycle after release.
- **NLP only:** drive `tx_nlp` high for 8 cycles. Required: `td_p` high for exactly 8 cycles with 1-cycle lag, `td_n = 0`, `nlp_skip = 0`.
- **Single-byte frame:** send 0xA5 with `tx_last` at the default parameters. Required:
  - 512 cycles of 0x55×7 + 0xD5, then 64 cycles of 0xA5 encoding (bit0 = 1: low then high).
  - Then 20 cycles of `td_p = 1`, `td_n = 0`, then both lines 0.
  - `tx_busy` high for 596 cycles.
- **Back-to-back bytes:** send 0x01, 0xFF, 0x00 (last) with `tx_valid` held high. Required: no gap between bytes, `underrun = 0`, and `tx_ready` toggles once per byte.
- **Underrun:** send 0x12 without `tx_last`, then nothing. Required: `underrun` pulses once at the end of that byte, followed by TPIDL then IDLE.
- **Collisions:**
  - Raise `tx_nlp` mid-frame. Required: `nlp_skip` pulse and no line disturbance.
  - Offer a byte while a link pulse is high in IDLE. Required: the pulse completes at full width, then PRE starts.
